// File: rtl/memgame_pkg.sv
// Shared types and helpers for the display source arbiter.
//   arb_state_t    : arbiter FSM states
//   SEL_*          : display mux select encodings
//   onehot_to_sel(): one-hot grant -> 2-bit mux select (index+1, 00 = none)
package memgame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_D1   = 2'b01;
    localparam logic [1:0] SEL_D2   = 2'b10;
    localparam logic [1:0] SEL_D3   = 2'b11;

    function automatic logic [1:0] onehot_to_sel(input logic [2:0] oh);
        logic [1:0] s;
        s = SEL_NONE;
        if (oh[0])      s = SEL_D1;
        else if (oh[1]) s = SEL_D2;
        else if (oh[2]) s = SEL_D3;
        return s;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker (combinational).
//   req  [2:0] : request bits, bit i = source i+1
//   last [1:0] : index of the most recently served source (0..2)
//   win  [2:0] : one-hot winner, searching last+1, last+2, last+3 (mod 3)
//   any        : at least one request is asserted
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] win,
    output logic       any
);

    always_comb begin
        win = 3'b000;
        case (last)
            2'd0: begin
                if (req[1])      win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd1: begin
                if (req[2])      win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            // last=2 (and the unused code 3) start the search at source 1
            default: begin
                if (req[0])      win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/display_src_arbiter.sv
// Arbiter/sequencer for the 3-source, 8-bit display select mux.
// Grants one producer at a time with a minimum on-screen time and a
// fairness limit, and inserts one blanking cycle between grants.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   req  [2:0] : per-source request (bit0 = pattern, bit1 = echo, bit2 = score)
//   gnt  [2:0] : registered one-hot grant, 000 = none
//   sel  [1:0] : registered mux select, 00 none / 01..11 source 1..3
//   busy       : high while a grant is active
//   hold_done  : high while the current grant has met MIN_HOLD
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant, arbitrating every cycle
// GRANT | gnt/sel show the owner, cnt counts cycles held
// GAP   | single blanking cycle after a grant, arbitrating for the next
module display_src_arbiter #(
    parameter int unsigned MIN_HOLD = 25_000_000,
    parameter int unsigned MAX_HOLD = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       hold_done
);

    import memgame_pkg::*;

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] MAX_LAST  = CW'(MAX_HOLD - 1);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    gnt_nxt;
    logic [1:0]    last, last_nxt;
    logic [2:0]    win;
    logic          any;
    logic          max_hit;
    logic          owner_req;
    logic          others_req;

    rr_pick3 u_pick (
        .req  (req),
        .last (last),
        .win  (win),
        .any  (any)
    );

    assign busy       = (state == GRANT);
    assign hold_done  = busy && (cnt >= HOLD_LAST);
    assign max_hit    = (cnt == MAX_LAST);
    assign owner_req  = |(req & gnt);
    assign others_req = |(req & ~gnt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        last_nxt  = last;
        case (state)
            IDLE, GAP: begin
                cnt_nxt = '0;
                if (any) begin
                    state_nxt = GRANT;
                    gnt_nxt   = win;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 3'b000;
                end
            end
            GRANT: begin
                if ((hold_done && !owner_req) || (max_hit && others_req)) begin
                    state_nxt = GAP;
                    gnt_nxt   = 3'b000;
                    cnt_nxt   = '0;
                    // sel is index+1 of the owner while granted
                    last_nxt  = sel - 2'd1;
                end else if (!max_hit) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 3'b000;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= 3'b000;
            sel   <= SEL_NONE;
            last  <= 2'd2;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            sel   <= onehot_to_sel(gnt_nxt);
            last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_display_src_arbiter.sv
module tb_display_src_arbiter;

    localparam int MIN_HOLD = 3;
    localparam int MAX_HOLD = 6;

    logic       clk;
    logic       reset_n;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       hold_done;

    int checks   = 0;
    int failures = 0;

    // reference model: who owns the display, for how many cycles, who was last served
    int m_owner;
    int m_age;
    int m_last;

    display_src_arbiter #(.MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .hold_done (hold_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 2;
    endtask

    task automatic model_edge(input logic [2:0] r);
        if (m_owner >= 0) begin
            if ((m_age >= MIN_HOLD && !r[m_owner]) ||
                (m_age >= MAX_HOLD && (r & ~(3'b001 << m_owner)) != 3'b000)) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_age   = 1;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [2:0] eg;
        logic [1:0] es;
        eg = (m_owner >= 0) ? 3'(3'b001 << m_owner) : 3'b000;
        es = (m_owner >= 0) ? 2'(m_owner + 1) : 2'b00;
        chk("model_gnt", 8'(gnt), 8'(eg));
        chk("model_sel", 8'(sel), 8'(es));
        chk("model_busy", 8'(busy), 8'(m_owner >= 0));
        chk("model_hold_done", 8'(hold_done), 8'(m_owner >= 0 && m_age >= MIN_HOLD));
    endtask

    task automatic step(input logic [2:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        model_check();
    endtask

    // called just after a sampling point (posedge+1); finishes at posedge+4
    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_gnt", 8'(gnt), 8'h00);
        chk("async_rst_sel", 8'(sel), 8'h00);
        chk("async_rst_busy", 8'(busy), 8'h00);
        chk("async_rst_hold_done", 8'(hold_done), 8'h00);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [2:0] rq;
        logic [2:0] eg;

        // 1. reset with all sources requesting
        model_reset();
        reset_n = 1'b0;
        req     = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sel", 8'(sel), 8'h00);
        chk("reset_gnt", 8'(gnt), 8'h00);
        chk("reset_busy", 8'(busy), 8'h00);
        #1 reset_n = 1'b1;
        step(3'b001);
        chk("first_gnt", 8'(gnt), 8'h01);
        chk("first_sel", 8'(sel), 8'h01);
        repeat (6) step(3'b000);

        // 2. one-cycle pulse still gets the minimum hold
        step(3'b010);
        chk("minhold_c1_gnt", 8'(gnt), 8'h02);
        chk("minhold_c1_hd", 8'(hold_done), 8'h00);
        step(3'b000);
        chk("minhold_c2_sel", 8'(sel), 8'h02);
        chk("minhold_c2_hd", 8'(hold_done), 8'h00);
        step(3'b000);
        chk("minhold_c3_gnt", 8'(gnt), 8'h02);
        chk("minhold_c3_hd", 8'(hold_done), 8'h01);
        step(3'b000);
        chk("minhold_gap_sel", 8'(sel), 8'h00);
        step(3'b000);
        chk("minhold_idle_busy", 8'(busy), 8'h00);

        // 3. round robin under full load, from the reset pointer
        reset_pulse();
        for (int i = 0; i < 27; i++) begin
            step(3'b111);
            eg = ((i % 7) == 6) ? 3'b000 : 3'(3'b001 << ((i / 7) % 3));
            chk("rr_gnt", 8'(gnt), 8'(eg));
        end
        repeat (8) step(3'b000);

        // 4. sole requester is never rotated away
        step(3'b100);
        for (int i = 0; i < 20; i++) begin
            step(3'b100);
            chk("sole_gnt", 8'(gnt), 8'h04);
        end
        step(3'b000);
        chk("sole_gap_sel", 8'(sel), 8'h00);
        chk("sole_gap_busy", 8'(busy), 8'h00);
        step(3'b000);
        chk("sole_idle_gnt", 8'(gnt), 8'h00);

        // 5. handover after the minimum hold
        repeat (4) step(3'b001);
        chk("handover_c4_gnt", 8'(gnt), 8'h01);
        step(3'b100);
        chk("handover_gap_sel", 8'(sel), 8'h00);
        step(3'b100);
        chk("handover_new_gnt", 8'(gnt), 8'h04);
        chk("handover_new_sel", 8'(sel), 8'h03);
        repeat (8) step(3'b000);

        // 6. async reset mid-grant restores the pointer
        step(3'b010);
        step(3'b010);
        chk("midgrant_gnt", 8'(gnt), 8'h02);
        reset_pulse();
        step(3'b110);
        chk("post_rst_gnt", 8'(gnt), 8'h02);
        chk("post_rst_sel", 8'(sel), 8'h02);
        repeat (8) step(3'b000);

        // randomized traffic against the model, with occasional resets
        rq = 3'b000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) reset_pulse();
            if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
            step(rq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
